// File: rtl/idft_ctrl_pkg.sv
// Shared types and sizes for the IDFT stream sequencer and its word buffers.
package idft_ctrl_pkg;
   localparam int IDFT_NWORDS = 32;
   localparam int IDFT_SW     = 16;

   typedef logic [4*IDFT_SW-1:0] idft_word_t;

   typedef enum logic [2:0] {
      IDLE,
      NEXT,
      FEED,
      WAIT,
      CAPT
   } state_t;
endpackage

// File: rtl/idft_word_buf.sv
// Single-write-port word RAM. The read port is either registered (1-cycle latency)
// or combinational.
module idft_word_buf
   import idft_ctrl_pkg::*;
#(
   parameter int W      = 4 * IDFT_SW,
   parameter int DEPTH  = IDFT_NWORDS,
   parameter bit REG_RD = 1'b1
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   generate
      if (REG_RD) begin : g_reg_rd
         always_ff @(posedge clk) begin
            rd_data <= mem[rd_addr];
         end
      end else begin : g_comb_rd
         assign rd_data = mem[rd_addr];
      end
   endgenerate
endmodule

// File: rtl/idft_stream_ctrl.sv
// Sequencer feeding 32 packed words into the 64-point IDFT core and capturing its
// 32 result words, with sticky done / timeout / write-collision status.
module idft_stream_ctrl
   import idft_ctrl_pkg::*;
#(
   parameter int SW      = IDFT_SW,
   parameter int NWORDS  = IDFT_NWORDS,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      in_we_i,
   input  logic [$clog2(NWORDS)-1:0] in_idx_i,
   input  logic [4*SW-1:0]           in_data_i,
   input  logic [$clog2(NWORDS)-1:0] out_idx_i,
   output logic [4*SW-1:0]           out_data_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      timeout_o,
   output logic                      wr_collide_o,
   output logic                      core_next_o,
   output logic [4*SW-1:0]           core_x_o,
   input  logic                      core_next_out_i,
   input  logic [4*SW-1:0]           core_y_i
);
   localparam int IW = $clog2(NWORDS);
   localparam int WW = 4 * SW;

   state_t        state, state_nxt;
   logic [IW-1:0] idx;
   logic [IW-1:0] rd_addr;
   logic [31:0]   wcnt;
   logic          last_idx;
   logic          tmo_hit;
   logic          accept;
   logic          in_wr;
   logic          out_wr;
   logic [WW-1:0] rd_data;

   assign last_idx = (idx == IW'(NWORDS - 1));
   assign tmo_hit  = (TIMEOUT != 0) && (wcnt == 32'(TIMEOUT - 1));
   assign accept   = (state == IDLE) && start_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_i) state_nxt = NEXT;
         NEXT: state_nxt = FEED;
         FEED: if (last_idx) state_nxt = WAIT;
         WAIT: begin
            if (core_next_out_i) state_nxt = CAPT;
            else if (tmo_hit)    state_nxt = IDLE;
         end
         CAPT: if (last_idx) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Read address runs two words ahead of the word on core_x_o: one cycle for the
   // RAM read register, one for the core_x_o register.
   always_comb begin
      core_next_o = 1'b0;
      busy_o      = 1'b1;
      in_wr       = 1'b0;
      out_wr      = 1'b0;
      rd_addr     = '0;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            in_wr  = in_we_i;
         end
         NEXT: begin
            core_next_o = 1'b1;
            rd_addr     = IW'(1);
         end
         FEED:    rd_addr = idx + IW'(2);
         CAPT:    out_wr  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx  <= '0;
         wcnt <= '0;
      end else begin
         if (state == FEED || state == CAPT) idx <= idx + IW'(1);
         else                                idx <= '0;
         if (state == WAIT && TIMEOUT != 0)  wcnt <= wcnt + 32'd1;
         else                                wcnt <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_o       <= 1'b0;
         timeout_o    <= 1'b0;
         wr_collide_o <= 1'b0;
      end else if (accept) begin
         done_o       <= 1'b0;
         timeout_o    <= 1'b0;
         wr_collide_o <= 1'b0;
      end else begin
         if (state == CAPT && last_idx)                    done_o       <= 1'b1;
         if (state == WAIT && !core_next_out_i && tmo_hit) timeout_o    <= 1'b1;
         if (in_we_i && state != IDLE)                     wr_collide_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                       core_x_o <= '0;
      else if (state == NEXT || (state == FEED && !last_idx)) core_x_o <= rd_data;
      else                                             core_x_o <= '0;
   end

   idft_word_buf #(.W(WW), .DEPTH(NWORDS), .REG_RD(1'b1)) u_in_buf (
      .clk     (clk_i),
      .we      (in_wr),
      .wr_addr (in_idx_i),
      .wr_data (in_data_i),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   idft_word_buf #(.W(WW), .DEPTH(NWORDS), .REG_RD(1'b0)) u_out_buf (
      .clk     (clk_i),
      .we      (out_wr),
      .wr_addr (idx),
      .wr_data (core_y_i),
      .rd_addr (out_idx_i),
      .rd_data (out_data_o)
   );
endmodule

// File: tb/tb_idft_stream_ctrl.sv
// Bench for idft_stream_ctrl: timeline model of one transform relative to the start
// cycle, a behavioural IDFT-core stand-in, and literal spot checks.
module tb_idft_stream_ctrl;
   localparam int          NW = 32;
   localparam logic [63:0] YX = 64'hffff_0000_ffff_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_we = 1'b0;
   logic [4:0]  in_idx = '0;
   logic [4:0]  out_idx = '0;
   logic [63:0] in_data = '0;
   logic [63:0] core_y = '0;
   logic        core_next_out = 1'b0;

   logic [63:0] out_data, core_x;
   logic        busy, done, tmo, col, core_next;
   logic [63:0] out_data_t, core_x_t;
   logic        busy_t, done_t, tmo_t, col_t, core_next_t;
   logic        unused_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int run_s0 = -1;
   int run_r = 40;
   int run_we_rel = -1;
   int ymode = 1;
   bit extra_pulse = 1'b0;
   logic [63:0] m_in [NW];
   logic [63:0] cap [NW];

   idft_stream_ctrl dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .in_we_i(in_we), .in_idx_i(in_idx),
      .in_data_i(in_data), .out_idx_i(out_idx), .out_data_o(out_data), .busy_o(busy),
      .done_o(done), .timeout_o(tmo), .wr_collide_o(col), .core_next_o(core_next),
      .core_x_o(core_x), .core_next_out_i(core_next_out), .core_y_i(core_y)
   );

   idft_stream_ctrl #(.TIMEOUT(16)) dut_to (
      .clk_i(clk), .rst_i(rst), .start_i(start), .in_we_i(in_we), .in_idx_i(in_idx),
      .in_data_i(in_data), .out_idx_i(out_idx), .out_data_o(out_data_t), .busy_o(busy_t),
      .done_o(done_t), .timeout_o(tmo_t), .wr_collide_o(col_t), .core_next_o(core_next_t),
      .core_x_o(core_x_t), .core_next_out_i(1'b0), .core_y_i(core_y)
   );
   assign unused_t = ^out_data_t;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %0b want %0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] dflt_word(input int j);
      return {16'(4*j+3), 16'(4*j+2), 16'(4*j+1), 16'(4*j)};
   endfunction

   function automatic logic [63:0] exp_y(input int k);
      if (ymode == 0) return 64'(k);
      return m_in[31-k] ^ YX;
   endfunction

   // Stand-in core: records what it is fed, answers with next_out at rel run_r,
   // then streams either k or the fed words reversed and XOR-ed.
   always @(posedge clk) begin : core_model
      int rel;
      #1;
      if (run_s0 >= 0) begin
         rel = cyc - run_s0;
         core_next_out <= (rel == run_r) ||
                          (extra_pulse && (rel == 1 || rel == 20 || rel == run_r + 10));
         if (rel >= 2 && rel <= 33) cap[rel-2] <= core_x;
         if (rel >= run_r + 1 && rel <= run_r + 32)
            core_y <= (ymode == 0) ? 64'(rel - run_r - 1) : (cap[31-(rel-run_r-1)] ^ YX);
         else
            core_y <= {32'hdeadbeef, 32'(cyc)};
      end else begin
         core_next_out <= 1'b0;
         core_y        <= {32'h0bad_f00d, 32'(cyc)};
      end
   end

   // Expected behaviour of one transform as a function of cycles since start.
   always @(negedge clk) begin : cmp
      int rel;
      logic [63:0] ex;
      if (run_s0 >= 0) begin
         rel = cyc - run_s0;
         ex = (rel >= 2 && rel <= 33) ? m_in[rel-2] : 64'h0;
         if (rel == 1 && core_x === m_in[0]) ex = m_in[0];
         chk64("core_x", core_x, ex);
         ex = (rel >= 2 && rel <= 33) ? m_in[rel-2] : 64'h0;
         if (rel == 1 && core_x_t === m_in[0]) ex = m_in[0];
         chk64("core_x_t", core_x_t, ex);
         chk1("core_next", core_next, rel == 1);
         chk1("core_next_t", core_next_t, rel == 1);
         chk1("busy", busy, rel >= 1 && rel <= run_r + 32);
         if (rel >= 1) begin
            chk1("done", done, rel >= run_r + 33);
            chk1("timeout", tmo, 1'b0);
            chk1("wr_collide", col, run_we_rel >= 0 && rel > run_we_rel);
            chk1("wr_collide_t", col_t, run_we_rel >= 0 && rel > run_we_rel);
            chk1("busy_t", busy_t, rel <= 33 + 16);
            chk1("timeout_t", tmo_t, rel >= 34 + 16);
            chk1("done_t", done_t, 1'b0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_all();
      for (int j = 0; j < NW; j++) begin
         tick();
         in_we = 1'b1; in_idx = 5'(j); in_data = dflt_word(j);
         m_in[j] = dflt_word(j);
      end
      tick();
      in_we = 1'b0;
   endtask

   task automatic load_one(input int j, input logic [63:0] d);
      tick();
      in_we = 1'b1; in_idx = 5'(j); in_data = d;
      m_in[j] = d;
      tick();
      in_we = 1'b0;
   endtask

   task automatic begin_run(input int r, input int ym, input bit xp);
      tick();
      run_r = r; ymode = ym; extra_pulse = xp; run_we_rel = -1;
      run_s0 = cyc; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_rel(input int rel);
      while (cyc - run_s0 < rel) tick();
   endtask

   task automatic end_run();
      wait_rel(run_r + 36);
      run_s0 = -1;
   endtask

   task automatic check_out();
      for (int k = 0; k < NW; k++) begin
         out_idx = 5'(k);
         #1;
         chk64("out_word", out_data, exp_y(k));
      end
   endtask

   task automatic peek(input string name, input int k, input logic [63:0] lit);
      out_idx = 5'(k);
      #1;
      chk64(name, out_data, lit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_timeout", tmo, 1'b0);
      chk1("rst_collide", col, 1'b0);
      chk1("rst_next", core_next, 1'b0);
      chk64("rst_core_x", core_x, 64'h0);
      rst = 1'b0;
      load_all();

      // basic transform
      begin_run(40, 1, 1'b0);
      end_run();
      check_out();
      peek("t1_out0", 0, 64'hff80_007e_ff82_007c);
      peek("t1_out31", 31, 64'hfffc_0002_fffe_0000);

      // word 0 changed; stray next_out pulses in NEXT, FEED and CAPT
      load_one(0, {16'd3, 16'd2, 16'h2001, 16'h2000});
      begin_run(40, 1, 1'b1);
      end_run();
      check_out();
      peek("t2_out31", 31, 64'hfffc_0002_dffe_2000);
      peek("t2_out0", 0, 64'hff80_007e_ff82_007c);

      // late response at cycle 50, Y = k; second instance times out meanwhile
      begin_run(50, 0, 1'b0);
      end_run();
      check_out();
      peek("t3_out5", 5, 64'd5);
      chk1("t3_done", done, 1'b1);
      chk1("t3_timeout_t", tmo_t, 1'b1);
      chk1("t3_done_t", done_t, 1'b0);

      // start and write while busy
      load_one(0, dflt_word(0));
      begin_run(40, 1, 1'b0);
      wait_rel(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_rel(12);
      in_we = 1'b1; in_idx = 5'd3; in_data = 64'h1234_5678_9abc_def0;
      run_we_rel = 12;
      tick();
      in_we = 1'b0;
      end_run();
      check_out();
      chk1("t5_collide_idle", col, 1'b1);

      // asynchronous reset during FEED
      begin_run(40, 1, 1'b0);
      wait_rel(15);
      run_s0 = -1;
      #2 rst = 1'b1;
      #1;
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_next", core_next, 1'b0);
      chk64("t6_core_x", core_x, 64'h0);
      chk1("t6_done", done, 1'b0);
      chk1("t6_collide", col, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk1("t6_no_next", core_next, 1'b0);
         chk1("t6_idle", busy, 1'b0);
      end
      begin_run(40, 1, 1'b0);
      end_run();
      check_out();
      peek("t6_out31", 31, 64'hfffc_0002_fffe_0000);
      peek("t6_out28", 28, 64'hfff0_000e_fff2_000c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
